// File: rtl/synth_pkg.sv
// Shared WM8731 configuration definitions: arbiter FSM states, codec address
// constants and the {register, data} control-word packer.
package synth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_GAP
  } arb_state_e;

  localparam logic [6:0] WM8731_PERIPH_ADDR   = 7'b0011010;
  localparam logic [6:0] WM8731_REG_RESET     = 7'h0F;
  localparam logic [6:0] WM8731_REG_SAMP_CTRL = 7'h08;

  function automatic logic [15:0] wm8731_pack_word(input logic [6:0] addr,
                                                   input logic [8:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/wm8731_cfg_arbiter.sv
// Round-robin arbiter feeding two-byte WM8731 writes into one I2C byte controller.
// Grant to i2c_enable is 2 cycles; requesters wait (req held) until their done pulse.
module wm8731_cfg_arbiter
  import synth_pkg::*;
#(
  parameter logic [6:0]  PERIPH_ADDR    = WM8731_PERIPH_ADDR,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [15:0] req_word0,
  input  logic [15:0] req_word1,
  output logic [1:0]  done,
  output logic        err,
  output logic        busy,
  output logic        i2c_enable,
  output logic        i2c_mode,
  output logic [6:0]  i2c_addr,
  output logic [7:0]  i2c_tx_byte,
  input  logic        i2c_ready
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [15:0]   WD_LAST  = 16'(TIMEOUT_CYCLES - 1);

  arb_state_e    state_q, state_d;
  logic [15:0]   word_q, word_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [15:0]   wd_q, wd_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    done_q, done_d;
  logic          err_q, err_d;

  logic          pick;
  logic [15:0]   wd_inc;
  logic          wd_expired;

  // Requester 1 wins a tie only when requester 0 was served last.
  assign pick       = req[1] & (~req[0] | ~last_q);
  assign wd_inc     = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
  assign wd_expired = (wd_q >= WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
      gap_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    owner_d = owner_q;
    last_d  = last_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    done_d  = '0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          owner_d = pick;
          word_d  = pick ? req_word1 : req_word0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        wd_d    = '0;
        state_d = ST_SEND_HI;
      end

      ST_SEND_HI, ST_SEND_LO: begin
        // A ready in the expiry cycle still counts as success.
        if (i2c_ready) begin
          wd_d = '0;
          if (state_q == ST_SEND_HI) begin
            state_d = ST_SEND_LO;
          end else begin
            done_d[owner_q] = 1'b1;
            last_d          = owner_q;
            gap_d           = '0;
            state_d         = ST_GAP;
          end
        end else if (wd_expired) begin
          done_d[owner_q] = 1'b1;
          err_d           = 1'b1;
          gap_d           = '0;
          state_d         = ST_GAP;
        end else begin
          wd_d = wd_inc;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign i2c_enable  = (state_q == ST_SEND_HI) || (state_q == ST_SEND_LO);
  assign i2c_mode    = 1'b1;
  assign i2c_addr    = PERIPH_ADDR;
  assign i2c_tx_byte = (state_q == ST_SEND_LO) ? word_q[7:0] : word_q[15:8];
  assign done        = done_q;
  assign err         = err_q;

endmodule
